// File: rtl/matrix_column_scanner.sv
`default_nettype none
// ============================================================================
// Module      : matrix_column_scanner
// Description : Time-multiplexed LED dot-matrix column scanner with a
//               double-buffered frame, programmable dwell and blanking gap.
//               Active-low row and column-select drive, all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_column_scanner #(
  parameter int COLUNE_SIZE   = 7,
  parameter int TOTAL_COLUNES = 5,
  parameter int DATA_WIDTH    = COLUNE_SIZE * TOTAL_COLUNES,
  parameter int DIV_WIDTH     = 16,
  parameter int BLANK_CYCLES  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     load,
  input  logic [DATA_WIDTH-1:0]    frame_data,
  input  logic [DIV_WIDTH-1:0]     div_value,
  output logic [COLUNE_SIZE-1:0]   row_out,
  output logic [TOTAL_COLUNES-1:0] col_sel,
  output logic                     frame_start,
  output logic                     pending
);

  localparam int IDX_W   = (TOTAL_COLUNES < 2) ? 1 : $clog2(TOTAL_COLUNES);
  localparam int BLANK_W = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_COLUNES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [DIV_WIDTH-1:0]    dwell, dwell_n;
  logic [BLANK_W-1:0]      bcnt, bcnt_n;
  logic                    enter_col0;

  logic [DATA_WIDTH-1:0]   active, shadow;
  logic [DATA_WIDTH-1:0]   active_n;
  logic                    swap;

  logic [DIV_WIDTH-1:0]    dwell_load;
  logic                    wrap;
  logic [IDX_W-1:0]        idx_inc;

  // A zero dwell request is stretched to one cycle so every column is shown.
  assign dwell_load = (div_value == '0) ? DIV_WIDTH'(1) : div_value;
  assign wrap       = (idx == LAST_IDX);
  assign idx_inc    = wrap ? '0 : idx + IDX_W'(1);

  // The swap happens only on the edge that starts column 0 of a new frame.
  assign swap     = enter_col0 && pending;
  assign active_n = swap ? shadow : active;

  // Next-state logic: scan sequencing, dwell and blank counting.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    dwell_n    = dwell;
    bcnt_n     = bcnt;
    enter_col0 = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      idx_n   = '0;
      dwell_n = '0;
      bcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n    = SHOW;
          idx_n      = '0;
          dwell_n    = dwell_load;
          enter_col0 = 1'b1;
        end
        SHOW: begin
          if (dwell <= DIV_WIDTH'(1)) begin
            if (BLANK_CYCLES > 0) begin
              state_n = BLANK;
              dwell_n = '0;
              bcnt_n  = BLANK_W'(BLANK_CYCLES);
            end else begin
              state_n    = SHOW;
              idx_n      = idx_inc;
              dwell_n    = dwell_load;
              enter_col0 = wrap;
            end
          end else begin
            dwell_n = dwell - DIV_WIDTH'(1);
          end
        end
        BLANK: begin
          if (bcnt <= BLANK_W'(1)) begin
            state_n    = SHOW;
            idx_n      = idx_inc;
            dwell_n    = dwell_load;
            bcnt_n     = '0;
            enter_col0 = wrap;
          end else begin
            bcnt_n = bcnt - BLANK_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          dwell_n = '0;
          bcnt_n  = '0;
        end
      endcase
    end
  end

  // Scan state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      dwell <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      dwell <= dwell_n;
      bcnt  <= bcnt_n;
    end
  end

  // Double buffer: a load arriving on the swap edge lands in shadow and stays pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      active <= active_n;
      if (load) begin
        shadow  <= frame_data;
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered pin drive derived from the next scan state, so rows and column
  // select always change together and never overlap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_out     <= '1;
      col_sel     <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= enter_col0;
      if (state_n == SHOW) begin
        row_out <= ~active_n[idx_n*COLUNE_SIZE +: COLUNE_SIZE];
        col_sel <= ~(TOTAL_COLUNES'(1) << idx_n);
      end else begin
        row_out <= '1;
        col_sel <= '1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_column_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_column_scanner
// Description : Randomized bench for matrix_column_scanner, two instances
//               (with and without blanking) against a frame-position model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_column_scanner;

  localparam int CS = 7;
  localparam int NC = 5;
  localparam int DW = CS * NC;
  localparam int VW = 16;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          load;
  logic [DW-1:0] frame_data;
  logic [VW-1:0] div_value;

  logic [CS-1:0] row_out [2];
  logic [NC-1:0] col_sel [2];
  logic          frame_start [2];
  logic          pending [2];

  int n_cmp = 0;
  int n_err = 0;

  matrix_column_scanner #(.COLUNE_SIZE(CS), .TOTAL_COLUNES(NC), .DIV_WIDTH(VW),
                          .BLANK_CYCLES(1)) dut_blank (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .frame_data(frame_data), .div_value(div_value),
    .row_out(row_out[0]), .col_sel(col_sel[0]),
    .frame_start(frame_start[0]), .pending(pending[0])
  );

  matrix_column_scanner #(.COLUNE_SIZE(CS), .TOTAL_COLUNES(NC), .DIV_WIDTH(VW),
                          .BLANK_CYCLES(0)) dut_noblank (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .frame_data(frame_data), .div_value(div_value),
    .row_out(row_out[1]), .col_sel(col_sel[1]),
    .frame_start(frame_start[1]), .pending(pending[1])
  );

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: position within the frame (column, cycle within column).
  int            m_blank [2] = '{1, 0};
  bit            m_run   [2];
  int            m_col   [2];
  int            m_t     [2];
  int            m_d     [2];
  logic [DW-1:0] m_act   [2];
  logic [DW-1:0] m_sh    [2];
  bit            m_pend  [2];
  logic [CS-1:0] e_row   [2];
  logic [NC-1:0] e_col   [2];
  bit            e_fs    [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_run[k]  = 0;
    m_col[k]  = 0;
    m_t[k]    = 0;
    m_d[k]    = 1;
    m_act[k]  = '0;
    m_sh[k]   = '0;
    m_pend[k] = 0;
    e_row[k]  = '1;
    e_col[k]  = '1;
    e_fs[k]   = 0;
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_step(input int k);
    bit new_frame;
    bit do_swap;
    int dmax;
    dmax = (div_value == 0) ? 1 : int'(div_value);
    new_frame = 0;
    if (reset) begin
      model_reset(k);
      return;
    end
    if (!enable) begin
      m_run[k] = 0;
    end else if (!m_run[k]) begin
      m_run[k] = 1;
      m_col[k] = 0;
      m_t[k]   = 0;
      m_d[k]   = dmax;
      new_frame = 1;
    end else begin
      m_t[k]++;
      if (m_t[k] == m_d[k] + m_blank[k]) begin
        m_col[k] = (m_col[k] + 1) % NC;
        m_t[k]   = 0;
        m_d[k]   = dmax;
        new_frame = (m_col[k] == 0);
      end
    end
    do_swap = new_frame && m_pend[k];
    if (do_swap) m_act[k] = m_sh[k];
    if (load) begin
      m_sh[k]   = frame_data;
      m_pend[k] = 1;
    end else if (do_swap) begin
      m_pend[k] = 0;
    end
    e_fs[k] = new_frame;
    if (m_run[k] && m_t[k] < m_d[k]) begin
      e_col[k] = ~(NC'(1) << m_col[k]);
      e_row[k] = ~m_act[k][m_col[k]*CS +: CS];
    end else begin
      e_col[k] = '1;
      e_row[k] = '1;
    end
  endtask

  task automatic check_all(input string phase);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s row_out[%0d]", phase, k), 64'(row_out[k]), 64'(e_row[k]));
      check($sformatf("%s col_sel[%0d]", phase, k), 64'(col_sel[k]), 64'(e_col[k]));
      check($sformatf("%s frame_start[%0d]", phase, k), 64'(frame_start[k]), 64'(e_fs[k]));
      check($sformatf("%s pending[%0d]", phase, k), 64'(pending[k]), 64'(m_pend[k]));
    end
  endtask

  // Stimulus and checking.
  initial begin
    logic [DW-1:0] basic_frame;
    basic_frame = '0;
    basic_frame[0 +: CS]  = 7'h41;
    basic_frame[CS +: CS] = 7'h22;

    reset = 1'b0; enable = 1'b0; load = 1'b0; frame_data = '0; div_value = '0;
    for (int k = 0; k < 2; k++) model_reset(k);
    #1 reset = 1'b1;
    #1 check_all("reset");

    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      check_all("scan");

      if (i < 3) begin
        reset = 1'b1;
        enable = 1'b0; load = 1'b0; div_value = 16'd3; frame_data = '0;
      end else if (i < 60) begin
        reset      = 1'b0;
        load       = (i == 3);
        frame_data = (i == 3) ? basic_frame : 35'({$urandom(), $urandom()});
        enable     = (i >= 4);
        div_value  = 16'd3;
      end else begin
        reset      = 1'b0;
        load       = ($urandom_range(0, 14) == 0);
        frame_data = 35'({$urandom(), $urandom()});
        if ($urandom_range(0, 39) == 0) enable = ~enable;
        else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
        if ($urandom_range(0, 29) == 0) div_value = 16'($urandom_range(0, 4));
        if ($urandom_range(0, 299) == 0) begin
          reset = 1'b1;
          #1;
          for (int k = 0; k < 2; k++) model_reset(k);
          check_all("async_reset");
        end
      end

      for (int k = 0; k < 2; k++) model_step(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
